// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock on a single state register.
// Round keys are fetched from an external key store through rk_idx/rk.
module aes_inv_cipher_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    if (NR != 10 && NR != 12 && NR != 14) begin : g_nr_check
        $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NR_IDX = 4'(NR);
    localparam logic [3:0] NR_M1  = 4'(NR - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_reg;
    logic [127:0] st_reg;
    logic [3:0]   rnd_reg;
    logic [127:0] out_block_reg;
    logic         in_ready_reg;
    logic         out_valid_reg;
    logic         busy_reg;
    logic [3:0]   rk_idx_reg;

    logic [127:0] sub_st;
    logic [127:0] ark_st;
    logic [127:0] imc_st;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse affine map, then GF(2^8) inverse as x^254 (0 maps to 0).
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] a;
        logic [7:0] p;
        logic [7:0] r;
        a = {s[1:0], s[7:2]} ^ {s[4:0], s[7:5]} ^ {s[6:0], s[7]} ^ 8'h05;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    // InvShiftRows folded into the byte wiring: row r rotates right by r columns.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int SRC = 4 * (((gi / 4) - (gi % 4) + 4) % 4) + (gi % 4);
        assign sub_st[127-8*gi -: 8] = inv_sbox(st_reg[127-8*SRC -: 8]);
    end

    assign ark_st = sub_st ^ rk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = ark_st[127-32*gi -: 8];
        assign a1 = ark_st[119-32*gi -: 8];
        assign a2 = ark_st[111-32*gi -: 8];
        assign a3 = ark_st[103-32*gi -: 8];
        assign imc_st[127-32*gi -: 32] = {
            gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
        };
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            st_reg        <= '0;
            rnd_reg       <= '0;
            out_block_reg <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            rk_idx_reg    <= NR_IDX;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        st_reg       <= in_block ^ rk;
                        rnd_reg      <= NR_M1;
                        rk_idx_reg   <= NR_M1;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    if (rnd_reg != 4'd0) begin
                        st_reg     <= imc_st;
                        rnd_reg    <= rnd_reg - 4'd1;
                        rk_idx_reg <= rnd_reg - 4'd1;
                    end else begin
                        // Final round skips InvMixColumns.
                        out_block_reg <= ark_st;
                        out_valid_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        rk_idx_reg    <= 4'd0;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        rk_idx_reg    <= NR_IDX;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    rk_idx_reg    <= NR_IDX;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_block = out_block_reg;
    assign busy      = busy_reg;
    assign rk_idx    = rk_idx_reg;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: one instance each for NR=10/12/14, driven by a
// forward-cipher reference model with a queue-based scoreboard per instance.
module tb_aes_inv_cipher_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk_tab [3][16];
    bit           tables_ok = 1'b0;

    typedef struct {
        logic [127:0] pt;
        int           acc;
    } exp_t;

    task automatic chk(input int nr, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL NR%0d %s: got %h, expected %h", nr, name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box: brute-force field inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] b;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
            sbox[x] = b ^ 8'h63;
        end
    endtask

    // Key bytes are 00,01,02,... up to the key length for this NR.
    task automatic expand_keys(input int g, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nk;
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++)
            w[i] = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_tab[g][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [127:0] encrypt(input int g, input int nr, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk_tab[g][0][127-8*k -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int k = 0; k < 16; k++) t[k] = sbox[s[k]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c+r] = t[4*((c + r) % 4) + r];
            if (rnd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk_tab[g][rnd][127-8*k -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_nr
        localparam int NRV = 10 + 2 * gi;
        localparam logic [127:0] CT = (gi == 0) ? 128'h69c4e0d86a7b0430d8cdb78070b4c55a :
                                      (gi == 1) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 :
                                                  128'h8ea2b7ca516745bfeafc49904b496089;
        localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

        logic         rst_n, in_valid, in_ready, out_valid, out_ready, busy;
        logic [127:0] in_block, rk, out_block;
        logic [3:0]   rk_idx;
        int           or_mode = 0;
        int           n_acc = 0;
        int           n_out = 0;
        bit           done = 1'b0;
        exp_t         q [$];

        assign rk = rk_tab[gi][rk_idx];

        aes_inv_cipher_iter #(.NR(NRV)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_block  (in_block),
            .rk_idx    (rk_idx),
            .rk        (rk),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_block (out_block),
            .busy      (busy)
        );

        // out_ready changes just after posedge: 0 = always 1, 1 = random, 2 = held low.
        initial begin : ordrv
            out_ready = 1'b1;
            forever begin
                @(posedge clk);
                #1;
                case (or_mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = ($urandom_range(0, 1) == 1);
                    default: out_ready = 1'b0;
                endcase
            end
        end

        initial begin : mon
            logic         prev_ov, prev_or;
            logic [127:0] prev_ob;
            prev_ov = 1'b0;
            prev_or = 1'b1;
            prev_ob = '0;
            forever begin
                @(negedge clk);
                if (prev_ov === 1'b1 && prev_or === 1'b0) begin
                    chk(NRV, "out_valid held", {127'h0, out_valid}, 128'h1);
                    chk(NRV, "out_block held", out_block, prev_ob);
                end
                if (out_valid === 1'b1 && prev_ov !== 1'b1) begin
                    if (q.size() == 0) chk(NRV, "spurious out_valid", {127'h0, out_valid}, 128'h0);
                    else chk(NRV, "latency", 128'(cyc - q[0].acc + 1), 128'(NRV + 1));
                end
                if (out_valid === 1'b1 && out_ready === 1'b1 && q.size() != 0) begin
                    chk(NRV, "out_block", out_block, q[0].pt);
                    $display("NR%0d out #%0d %h", NRV, n_out, out_block);
                    void'(q.pop_front());
                    n_out++;
                end
                prev_ov = out_valid;
                prev_or = out_ready;
                prev_ob = out_block;
            end
        end

        // Called at a negedge; returns at the negedge after the accepting edge.
        task automatic send(input logic [127:0] ct, input logic [127:0] pt);
            int n;
            n = 0;
            in_valid = 1'b1;
            in_block = ct;
            while (in_ready !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (in_ready !== 1'b1) begin
                chk(NRV, "accept timeout", {127'h0, in_ready}, 128'h1);
            end else begin
                chk(NRV, "rk_idx at accept", {124'h0, rk_idx}, 128'(NRV));
                q.push_back('{pt: pt, acc: cyc + 1});
                n_acc++;
            end
            @(negedge clk);
            in_valid = 1'b0;
        endtask

        task automatic drain(input int bound);
            int n;
            n = 0;
            while (q.size() != 0 && n < bound) begin
                @(negedge clk);
                n++;
            end
            chk(NRV, "queue drained", 128'(q.size()), 128'h0);
        endtask

        initial begin : drv
            logic [127:0] pt, pt2;
            int n;
            rst_n    = 1'b0;
            in_valid = 1'b0;
            in_block = '0;
            wait (tables_ok);
            @(negedge clk);
            chk(NRV, "reset in_ready", {127'h0, in_ready}, 128'h1);
            chk(NRV, "reset out_valid", {127'h0, out_valid}, 128'h0);
            chk(NRV, "reset busy", {127'h0, busy}, 128'h0);
            chk(NRV, "reset out_block", out_block, 128'h0);
            chk(NRV, "reset rk_idx", {124'h0, rk_idx}, 128'(NRV));
            rst_n = 1'b1;
            @(negedge clk);

            // FIPS-197 vector with rk_idx sequence
            send(CT, PT);
            for (int k = 1; k <= NRV; k++) begin
                chk(NRV, "rk_idx in RUN", {124'h0, rk_idx}, 128'(NRV - k));
                chk(NRV, "busy in RUN", {127'h0, busy}, 128'h1);
                @(negedge clk);
            end
            chk(NRV, "rk_idx in DONE", {124'h0, rk_idx}, 128'h0);
            chk(NRV, "busy in DONE", {127'h0, busy}, 128'h0);
            chk(NRV, "in_ready in DONE", {127'h0, in_ready}, 128'h0);
            drain(50);

            // Back-pressure with a second block waiting on in_valid
            pt2 = 128'h0123456789abcdeffedcba9876543210;
            or_mode = 2;
            @(negedge clk);
            send(CT, PT);
            in_valid = 1'b1;
            in_block = encrypt(gi, NRV, pt2);
            n = 0;
            while (out_valid !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk(NRV, "out_valid rises", {127'h0, out_valid}, 128'h1);
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                chk(NRV, "in_ready under back-pressure", {127'h0, in_ready}, 128'h0);
            end
            or_mode = 0;
            n = 0;
            while (!(out_valid === 1'b1 && out_ready === 1'b1) && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk(NRV, "output handshake", {127'h0, out_valid & out_ready}, 128'h1);
            @(negedge clk);
            chk(NRV, "in_ready after handshake", {127'h0, in_ready}, 128'h1);
            q.push_back('{pt: pt2, acc: cyc + 1});
            n_acc++;
            @(negedge clk);
            chk(NRV, "second block accepted", {127'h0, in_ready}, 128'h0);
            in_valid = 1'b0;
            drain(50);

            // Reset in the middle of a decryption
            send(CT, PT);
            repeat (4) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            q.delete();
            chk(NRV, "in_ready after reset", {127'h0, in_ready}, 128'h1);
            chk(NRV, "rk_idx after reset", {124'h0, rk_idx}, 128'(NRV));
            chk(NRV, "out_valid after reset", {127'h0, out_valid}, 128'h0);
            repeat (NRV + 4) @(negedge clk);
            send(CT, PT);
            drain(50);

            // Back-to-back random blocks with random out_ready
            n_acc = 0;
            n_out = 0;
            or_mode = 1;
            for (int i = 0; i < 100; i++) begin
                pt = {$urandom(), $urandom(), $urandom(), $urandom()};
                send(encrypt(gi, NRV, pt), pt);
            end
            drain(300);
            chk(NRV, "blocks delivered", 128'(n_out), 128'(n_acc));
            or_mode = 0;
            done = 1'b1;
        end
    end

    initial begin : main
        int n;
        build_sbox();
        for (int g = 0; g < 3; g++) expand_keys(g, 10 + 2 * g);
        tables_ok = 1'b1;
        n = 0;
        while (!(g_nr[0].done && g_nr[1].done && g_nr[2].done) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (!(g_nr[0].done && g_nr[1].done && g_nr[2].done)) begin
            checks++;
            fails++;
            $display("FAIL global timeout: drivers not done after %0d cycles", n);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative AES inverse-cipher engine. It decrypts one 128-bit block at a time by running one inverse round per clock on a single registered state. The round datapath is built from the team's existing inverse ShiftRows, inverse SubBytes, AddRoundKey and InvMixColumns blocks. Key length (AES-128/192/256) is selected by parameter, round keys come from an external key-schedule store over an indexed lookup port, and valid/ready handshakes sit on both input and output.

## Interface
- NR, default 10: number of rounds; legal values 10, 12, 14; any other value is an elaboration error.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset: synchronous, active-low.
- in_valid  input  1  in_block is valid.
- in_ready  output  1  engine can accept a block.
- in_block  input  128  ciphertext block.
- rk_idx  output  4  index of the round key needed this cycle.
- rk  input  128  round key rk_idx; combinational, valid in the same cycle.
- out_valid  output  1  out_block holds a finished plaintext.
- out_ready  input  1  consumer accepts out_block.
- out_block  output  128  plaintext result.
- busy  output  1  high while rounds are executing.

## Operation
- FSM states:
  - IDLE: in_ready=1, rk_idx=NR.
  - RUN: rk_idx=rnd.
  - DONE: out_valid=1, rk_idx=0.
- IDLE → RUN on in_valid&in_ready:
  - st <= in_block ^ rk (initial AddRoundKey with key NR).
  - rnd <= NR-1.
- RUN with rnd≥1:
  - st <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(st)), rk)).
  - rnd <= rnd-1.
- RUN with rnd==0 (final round, no InvMixColumns):
  - out_block <= AddRoundKey(InvSubBytes(InvShiftRows(st)), rk).
  - Go to DONE.
- DONE → IDLE on out_ready.
  - out_block holds its value until the next result is written.
- in_valid outside IDLE is ignored; in_ready is 0 there, so no handshake occurs.
- No same-cycle accept in DONE: a new block is accepted only in IDLE, one cycle after the output handshake.
- Byte order: bit 127 is byte 0 (FIPS-197 column-major, first byte MSB), matching the existing transform blocks.
- rnd is 4 bits and counts down only, so it has no wrap-around. Reaching 0 in RUN always forces exit.
- busy = (state==RUN).

## Timing
- Reset (rst_n low at a clk edge) puts the FSM in IDLE with:
  - in_ready=1, out_valid=0, busy=0
  - out_block=0, st=0, rnd=0
  - rk_idx=NR
- Reset mid-operation discards the block in flight. There is no partial output, and out_valid stays 0.
- Input accepted at edge E:
  - Rounds execute on edges E+1 … E+NR.
  - out_valid is first seen high in the cycle following edge E+NR, which gives a latency of NR+1 edges.
- rk_idx sequence seen by the key store for one block: NR, NR-1, …, 1, 0.
  - Each value is held exactly one cycle during accept and RUN.
  - rk must be stable before the edge that uses it.
- Throughput with out_ready held high: one block per NR+2 cycles (accept, NR rounds, 1 DONE cycle).
- Output back-pressure: while out_ready=0 in DONE, out_valid and out_block stay stable and in_ready stays 0.
- in_ready and rk_idx are decoded from state only; there is no combinational path from in_valid or out_ready.

## Test plan
- NR=10, FIPS-197 C.1:
  - Stimulus: round keys expanded from key 000102030405060708090a0b0c0d0e0f; in_block 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: out_block 00112233445566778899aabbccddeeff, out_valid exactly 11 edges after accept, rk_idx sequence 10…0.
- NR=12, FIPS-197 C.2:
  - Stimulus: key 000102…1617, ciphertext dda97ca4864cdfe06eaf70a0ec0d7191.
  - Required: plaintext 00112233445566778899aabbccddeeff, latency 13.
- NR=14, FIPS-197 C.3:
  - Stimulus: key 000102…1e1f, ciphertext 8ea2b7ca516745bfeafc49904b496089.
  - Required: plaintext 00112233445566778899aabbccddeeff, latency 15.
- Back-pressure and ignored input:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid; keep in_valid=1 with a second block throughout.
  - Required: out_block stays constant; in_ready stays 0; the second block is accepted exactly one cycle after the out_ready handshake and decrypts correctly.
- Reset mid-run:
  - Stimulus: pull rst_n low at round 5 of a C.1 decryption for one edge, then release.
  - Required: out_valid never rises for that block, in_ready=1 and rk_idx=NR the next cycle, and a fresh C.1 run then decrypts correctly.
- Back-to-back streaming:
  - Stimulus: 100 random blocks against a reference model, with out_ready random at 50%.
  - Required: all outputs match, in order, and no accepted block is lost.
